// File: rtl/channel_err_ctrl.sv
// channel_err_ctrl: bit-serial error injector that inverts up to three LFSR-chosen bits per 63-bit frame.
// Define CHANNEL_ERR_STATS_EN to build the frame/error statistics counters (tied to zero otherwise).
module channel_err_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic        data_in,
  output logic        valid_out,
  input  logic        ready_out,
  output logic        data_out,
  input  logic        enable,
  input  logic [1:0]  num_err,
  input  logic [5:0]  seed,
  input  logic        seed_load,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int unsigned IDX_W = 6;
  localparam int unsigned NSLOT = 3;
  localparam int unsigned CNT_W = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(62);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] lfsr;
  logic [IDX_W-1:0] pos [NSLOT];
  logic [1:0]       npos;
  logic [1:0]       nerr;

  logic             xfer;
  logic             hit;
  logic             cand_dup;
  logic             last;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] lfsr_nxt;
  logic [IDX_W-1:0] idx_inc;

  // Stream is zero-latency; only PICK stalls both directions.
  assign ready_in  = (state != PICK) & ready_out;
  assign valid_out = (state != PICK) & valid_in;
  assign data_out  = data_in ^ ((state == RUN) & hit);
  assign xfer      = valid_in & ready_in;

  assign lfsr_nxt = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
  assign cand     = lfsr - IDX_W'(1);
  assign last     = (idx == LAST_IDX);
  assign idx_inc  = last ? '0 : idx + IDX_W'(1);

  // Only the first npos slots hold live positions.
  always_comb begin
    hit      = 1'b0;
    cand_dup = 1'b0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (2'(i) < npos) begin
        if (pos[i] == idx)  hit      = 1'b1;
        if (pos[i] == cand) cand_dup = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      lfsr  <= IDX_W'(1);
      npos  <= '0;
      nerr  <= '0;
      busy  <= 1'b0;
      for (int unsigned i = 0; i < NSLOT; i++) pos[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_load) lfsr <= (seed == '0) ? IDX_W'(1) : seed;
          if (xfer) begin
            idx <= idx_inc;
          end else if (enable && idx == '0) begin
            state <= PICK;
            busy  <= 1'b1;
            nerr  <= num_err;
          end
        end
        PICK: begin
          lfsr <= lfsr_nxt;
          if (nerr == '0) begin
            state <= RUN;
            busy  <= 1'b0;
          end else if (!cand_dup) begin
            for (int unsigned i = 0; i < NSLOT; i++)
              if (npos == 2'(i)) pos[i] <= cand;
            npos <= npos + 2'd1;
            if (npos + 2'd1 == nerr) begin
              state <= RUN;
              busy  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            idx <= idx_inc;
            // Frame boundary: drop positions and resample enable/num_err.
            if (last) begin
              npos <= '0;
              if (enable) begin
                state <= PICK;
                busy  <= 1'b1;
                nerr  <= num_err;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHANNEL_ERR_STATS_EN
  logic [CNT_W-1:0] frame_q;
  logic [CNT_W-1:0] err_q;

  // Saturating statistics, counted only on accepted RUN bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
      err_q   <= '0;
    end else if (state == RUN && xfer) begin
      if (hit && err_q != '1)   err_q   <= err_q + CNT_W'(1);
      if (last && frame_q != '1) frame_q <= frame_q + CNT_W'(1);
    end
  end

  assign frame_cnt = frame_q;
  assign err_cnt   = err_q;
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_channel_err_ctrl.sv
// tb_channel_err_ctrl: directed bench for channel_err_ctrl with hand-derived inversion masks.
// Counter expectations follow CHANNEL_ERR_STATS_EN.
module tb_channel_err_ctrl;

`ifdef CHANNEL_ERR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        ready_in;
  logic        data_in;
  logic        valid_out;
  logic        ready_out;
  logic        data_out;
  logic        enable;
  logic [1:0]  num_err;
  logic [5:0]  seed;
  logic        seed_load;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  channel_err_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .enable    (enable),
    .num_err   (num_err),
    .seed      (seed),
    .seed_load (seed_load),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnts(input string tag, input int frames, input int errs);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), exp_cnt(frames));
    chk({tag, "_err_cnt"},   32'(err_cnt),   exp_cnt(errs));
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0; ready_out = 1'b1; data_in = 1'b0;
    enable = 1'b0; num_err = 2'd0; seed = 6'h00; seed_load = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hs", 32'({ready_in, valid_out}), 32'b10);
    chk_cnts("rst", 0, 0);
    rst = 1'b0;
  endtask

  // Called in the first PICK cycle; returns once busy drops.
  task automatic pick_phase(input int exp_picks);
    int n;
    n = 0;
    valid_in = 1'b1; ready_out = 1'b1;
    #1;
    chk("pick_stall", 32'({busy, ready_in, valid_out}), 32'b100);
    while (busy === 1'b1 && n < 16) begin
      tick();
      n++;
    end
    chk("pick_cycles", 32'(n), 32'(exp_picks));
  endtask

  task automatic xfer_bit(input logic [62:0] mask, input int b);
    logic d;
    logic m;
    d = 1'($urandom);
    m = mask[b];
    valid_in = 1'b1; ready_out = 1'b1; data_in = d;
    #1;
    chk($sformatf("hs_bit%0d", b), 32'({valid_out, ready_in}), 32'b11);
    chk($sformatf("data_bit%0d", b), 32'(data_out), 32'(d ^ m));
    tick();
  endtask

  task automatic run_bits(input logic [62:0] mask, input int lo, input int hi);
    for (int b = lo; b <= hi; b++) xfer_bit(mask, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Seed 1, two errors: positions 0,1; RUN-time seed_load ignored, num_err resampled at boundary.
    do_reset();
    seed = 6'h01; seed_load = 1'b1; enable = 1'b1; num_err = 2'd2;
    tick();
    seed_load = 1'b0;
    pick_phase(2);
    num_err = 2'd1; seed = 6'h06; seed_load = 1'b1;
    run_bits(63'h3, 0, 62);
    chk_cnts("frame_a", 1, 2);
    seed_load = 1'b0;
    // lfsr continues at 4 -> single position 3; enable dropped mid-frame.
    pick_phase(1);
    run_bits(63'h8, 0, 19);
    enable = 1'b0;
    run_bits(63'h8, 20, 62);
    chk("idle_busy", 32'(busy), 32'd0);
    chk_cnts("frame_b", 2, 3);
    valid_in = 1'b1; ready_out = 1'b0; data_in = 1'b1;
    #1;
    chk("idle_stall", 32'({ready_in, valid_out, data_out}), 32'b011);
    run_bits(63'h0, 0, 2);
    chk("idle_stays", 32'(busy), 32'd0);

    // Seed 0 loads 1; three errors at 0,1,3.
    do_reset();
    seed = 6'h00; seed_load = 1'b1; enable = 1'b1; num_err = 2'd3;
    tick();
    seed_load = 1'b0;
    pick_phase(3);
    enable = 1'b0;
    run_bits(63'hB, 0, 62);
    chk_cnts("ne3", 1, 3);

    // num_err = 0: one PICK cycle, clean frame.
    do_reset();
    enable = 1'b1; num_err = 2'd0;
    tick();
    pick_phase(1);
    enable = 1'b0;
    run_bits(63'h0, 0, 62);
    chk_cnts("ne0", 1, 0);

    // Seed 6: positions 5 and 11; downstream stall while sitting on idx 5.
    do_reset();
    seed = 6'h06; seed_load = 1'b1; enable = 1'b1; num_err = 2'd2;
    tick();
    seed_load = 1'b0;
    pick_phase(2);
    enable = 1'b0;
    run_bits(63'h820, 0, 4);
    repeat (10) begin
      valid_in = 1'b1; ready_out = 1'b0; data_in = 1'b0;
      #1;
      chk("stall_hs", 32'({ready_in, valid_out}), 32'b01);
      chk("stall_data", 32'(data_out), 32'd1);
      tick();
    end
    chk_cnts("stall", 0, 0);
    valid_in = 1'b0; ready_out = 1'b1;
    #1;
    chk("bubble_hs", 32'({ready_in, valid_out}), 32'b10);
    tick();
    xfer_bit(63'h820, 5);
    chk_cnts("after_idx5", 0, 1);
    run_bits(63'h820, 6, 62);
    chk_cnts("stall_frame", 1, 2);

    // Reset at idx 30 abandons the frame.
    do_reset();
    seed = 6'h01; seed_load = 1'b1; enable = 1'b1; num_err = 2'd3;
    tick();
    seed_load = 1'b0;
    pick_phase(3);
    run_bits(63'hB, 0, 29);
    chk_cnts("pre_rst", 0, 3);
    rst = 1'b1; valid_in = 1'b1; ready_out = 1'b1; enable = 1'b0;
    tick();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hs", 32'({ready_in, valid_out}), 32'b11);
    chk_cnts("midrst", 0, 0);
    rst = 1'b0;
    run_bits(63'h0, 0, 4);
    chk_cnts("post_rst", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/channel_err_ctrl.md
CHANNEL_ERR_CTRL -- requirements
Module: channel_err_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-002 The block SHALL have these stream ports:
- valid_in input 1 (upstream bit valid).
- ready_in output 1 (block accepts upstream bit).
- data_in input 1 (upstream codeword bit).
- valid_out output 1 (downstream bit valid).
- ready_out input 1 (downstream accepts bit).
- data_out output 1 (bit, possibly inverted).
REQ-003 The block SHALL have these control ports:
- enable input 1 (error injection on; sampled only at frame boundary).
- num_err input 2 (errors per 63-bit frame, 0..3).
- seed input 6 (LFSR seed).
- seed_load input 1 (load seed pulse).
- busy output 1 (high in PICK).
REQ-004 The block SHALL have these statistics ports:
- frame_cnt output 16 (frames completed with injection).
- err_cnt output 16 (bits inverted).

Function
REQ-005 The block SHALL treat a frame as 63 transferred bits, indexed 0..62 by a 6-bit idx; a transfer is valid_in & ready_in.
- idx increments on every transfer in IDLE and RUN.
- idx wraps 62->0.
REQ-006 The FSM SHALL have the states IDLE, PICK and RUN.
REQ-007 In IDLE, the block SHALL pass the stream through unmodified: ready_in=ready_out, valid_out=valid_in, data_out=data_in.
REQ-008 The FSM SHALL go IDLE->PICK on a cycle where enable=1 and idx=0 and no transfer occurs; when a transfer occurs, it stays IDLE.
REQ-009 In PICK, the block SHALL stall the stream: ready_in=0, valid_out=0, busy=1.
REQ-010 The LFSR SHALL be 6 bits, with next = {lfsr[4:0], lfsr[5]^lfsr[4]}, and SHALL advance once per PICK cycle.
REQ-011 Each PICK cycle SHALL use candidate position = lfsr-1 (range 0..62); the candidate is stored as the next position unless it equals one already stored, in which case it is discarded.
REQ-012 The FSM SHALL leave PICK for RUN in the cycle after num_err distinct positions are stored; num_err (latched on PICK entry) =0 SHALL take exactly 1 PICK cycle and store none.
REQ-013 In RUN, the block SHALL connect the stream combinationally with zero latency: ready_in=ready_out, valid_out=valid_in, data_out=data_in ^ hit, where hit=1 iff idx equals a stored position.
REQ-014 On the transfer at idx=62 in RUN, the FSM SHALL go to PICK if enable=1, else to IDLE; on the same edge, stored positions are cleared.
REQ-015 Changes on num_err or enable during PICK or RUN SHALL have no effect until the next frame boundary.
REQ-016 seed_load SHALL load lfsr=seed only in IDLE (seed=0 loads 6'h01) and SHALL be ignored in PICK and RUN.
REQ-017 Counters SHALL saturate at 16'hFFFF:
- err_cnt increments on each RUN transfer with hit=1.
- frame_cnt increments on each RUN transfer at idx=62.
REQ-018 valid_out SHALL never depend on ready_out, and ready_in SHALL never depend on valid_in.

Reset
REQ-019 While rst=1 at a rising edge, the block SHALL set: state=IDLE, idx=0, lfsr=6'h01, stored positions cleared, frame_cnt=0, err_cnt=0.
REQ-020 Outputs during and after reset SHALL follow the IDLE rules, with busy=0.
REQ-021 A reset mid-frame SHALL abandon the frame, with no further inversion.

Configuration
REQ-022 Macro CHANNEL_ERR_STATS_EN compiles the counters in or out:
- Defined: frame_cnt and err_cnt SHALL behave per REQ-017.
- Undefined: no counter registers SHALL exist, and frame_cnt and err_cnt SHALL be tied to 16'h0000.

Verification
REQ-023 Reset, seed_load=1 with seed=6'h01, enable=1, num_err=2, continuous valid/ready, data_in all 0 -> 2 PICK cycles; data_out=1 at idx 0 and 1 only; err_cnt=2 and frame_cnt=1 after 63 bits.
REQ-024 Same as REQ-023 with num_err=3 -> data_out=1 at idx 0, 1 and 3 only; err_cnt=3.
REQ-025 enable=1, num_err=0 -> exactly 1 PICK cycle per frame; data_out equals data_in for all 63 bits; err_cnt=0; frame_cnt=1.
REQ-026 ready_out low for 10 cycles at idx=5 in RUN -> ready_in=0, idx holds at 5, no lost or duplicated bits; an inversion scheduled at idx 5 is applied once.
REQ-027 enable deasserted mid-frame -> the current frame completes with injection, then IDLE passthrough; asserting rst at idx=30 -> IDLE next cycle, counters at 0.
REQ-028 With CHANNEL_ERR_STATS_EN undefined, the REQ-023 stimulus -> same data_out, frame_cnt=err_cnt=0.
